clk_div_ctrl: RTL
=================

# clk_div_ctrl

Run-time controller for the programmable clock divider. It takes divide-ratio updates over a valid/ready handshake and applies each one only at an output-period boundary, so `clk_out` never glitches or shortens a phase. It starts and stops the divided clock cleanly under an enable and flags illegal ratios. It replaces the fixed-ratio counter dividers (÷2/÷3/÷4) wherever the ratio must change in operation.

## Interface
- `DIV_W`, 8: width of the divide ratio; legal ratios are 2 .. 2^DIV_W−1.
- `RESET_DIV`, 2: ratio loaded at reset; must be ≥2.
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `en`  in  1  run request; level-sensitive.
- `cfg_valid`  in  1  new ratio offered.
- `cfg_div`  in  DIV_W  offered ratio.
- `cfg_ready`  out  1  controller can accept a ratio.
- `clk_out`  out  1  divided clock, driven directly from a flop.
- `tick`  out  1  one-`clk` pulse in the last cycle of each output period.
- `busy`  out  1  divider running (state ≠ IDLE).
- `cfg_err`  out  1  one-cycle pulse: offered ratio was rejected.
- `period_cnt`  out  16  completed output periods; present only with `CLKDIV_PCNT_EN`.

## Operation
- Reset values: state IDLE, `div_q`=RESET_DIV, `cnt`=0, `clk_out`=0, `tick`=0, `cfg_ready`=1, `cfg_err`=0, `busy`=0, `period_cnt`=0.
- States:
  - IDLE: `clk_out` is held at 0. A sampled `en`=1 moves to RUN with `cnt`=0 and `clk_out`=1.
  - RUN: `cnt` counts 0 .. N−1, where N=`div_q`. `clk_out`=1 while `cnt` < floor(N/2), else 0. Duty: ÷3 gives 1 high / 2 low; ÷4 gives 2 high / 2 low.
  - PEND: like RUN, but a new ratio is held in `div_nxt`.
- Handshake: transfer happens when `cfg_valid` and `cfg_ready` are both high on a rising edge. `cfg_ready` = (state ≠ PEND). `cfg_div` is sampled only on a transfer.
- Ratio rules:
  - A transferred `cfg_div` < 2 is dropped. `cfg_err`=1 the next cycle and the state does not change.
  - Transfer in IDLE: `div_q` updates on the same edge.
  - Transfer in RUN when `cnt` ≠ N−1: go to PEND.
  - Transfer in RUN when `cnt` = N−1: the new ratio applies to the very next period and the state stays RUN.
- Boundary: the cycle with `cnt`=N−1. At its closing edge:
  - `cnt` goes to 0.
  - In PEND, `div_q` ← `div_nxt` and the state goes to RUN.
  - If `en`=0, the state goes to IDLE and `clk_out`=0. A pending ratio is still applied first.
- Graceful stop: `en` dropping mid-period does not truncate the period. The stop happens at the next boundary, and `busy` stays 1 until then.
- `en` re-asserted before the boundary: running continues with no gap.
- Reset asserted at any point: all reset values are restored at the next edge and any pending ratio is lost.

## Timing
- `en` sampled high at edge E0 (state IDLE): `clk_out`=1 and `busy`=1 from E0.
- Period: exactly N `clk` cycles, and the first period after start is full length.
- `tick` is high in the cycle where `cnt`=N−1 (registered, aligned with the last low phase).
- Ratio change: `clk_out` under the new ratio begins on the edge following the boundary. Worst-case latency from transfer is N_old cycles.
- `cfg_ready` goes low the cycle after a RUN transfer and returns high the cycle after the boundary.
- `cfg_err` appears 1 cycle after the rejected transfer.

## Configuration
- `CLKDIV_PCNT_EN` defined:
  - Adds the 16-bit `period_cnt` output.
  - It increments on every `tick` and wraps from 0xFFFF to 0x0000.
  - It holds its value in IDLE and clears only on reset.
- Not defined: the port and its counter are absent. All other behaviour is identical.

## Test plan
- Reset, then `en`=1 with default ÷2: `clk_out` toggles every cycle, `tick` fires on every low cycle, and `busy`=1 from the first edge.
- In IDLE, transfer `cfg_div`=5, then `en`=1: `clk_out` runs 2 cycles high, 3 low, with a 5-cycle period; `tick` fires every 5th cycle.
- Running ÷4, transfer `cfg_div`=3 at `cnt`=1:
  - `cfg_ready`=0 until the boundary.
  - The current period completes as 2 high / 2 low.
  - The next period is 1 high / 2 low.
  - A second `cfg_valid` during PEND is not accepted.
- Running ÷6, drop `en` at `cnt`=2: the period finishes its full 6 cycles, then `clk_out`=0 and `busy`=0; no runt pulse appears.
- Transfer `cfg_div`=0 and then `cfg_div`=1: each produces a `cfg_err` pulse, and `div_q` and `clk_out` are unchanged.
- Assert `rst_n`=0 while in PEND: all outputs return to reset values the next cycle. With `CLKDIV_PCNT_EN`, 65536 ticks wrap `period_cnt` to 0.

Source files
------------

// File: rtl/clk_div_ctrl.sv
// Run-time programmable clock divider controller with glitch-free ratio updates and graceful stop.
// Optional period counter output enabled by defining CLKDIV_PCNT_EN.
module clk_div_ctrl #(
  parameter int DIV_W     = 8,
  parameter int RESET_DIV = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             clk_out,
  output logic             tick,
  output logic             busy,
  output logic             cfg_err
`ifdef CLKDIV_PCNT_EN
  ,
  output logic [15:0]      period_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_nxt;

  logic             xfer;
  logic             bad_ratio;
  logic             good_ratio;
  logic             boundary;
  logic [DIV_W-1:0] div_after;
  logic [DIV_W-1:0] cnt_inc;

  // A ratio offered exactly on the boundary cycle goes straight into the next period.
  always_comb begin
    xfer       = cfg_valid && cfg_ready;
    bad_ratio  = xfer && (cfg_div < DIV_W'(2));
    good_ratio = xfer && !bad_ratio;
    boundary   = (state != IDLE) && (cnt == div_q - DIV_W'(1));
    cnt_inc    = cnt + DIV_W'(1);
    if (state == PEND)
      div_after = div_nxt;
    else if (good_ratio)
      div_after = cfg_div;
    else
      div_after = div_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      div_q     <= DIV_W'(RESET_DIV);
      div_nxt   <= DIV_W'(RESET_DIV);
      clk_out   <= 1'b0;
      tick      <= 1'b0;
      cfg_ready <= 1'b1;
      cfg_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      cfg_err <= bad_ratio;
      case (state)
        IDLE: begin
          tick <= 1'b0;
          if (good_ratio)
            div_q <= cfg_div;
          if (en) begin
            state   <= RUN;
            cnt     <= '0;
            clk_out <= 1'b1;
            busy    <= 1'b1;
          end else begin
            clk_out <= 1'b0;
          end
        end
        RUN, PEND: begin
          if (boundary) begin
            cnt       <= '0;
            div_q     <= div_after;
            tick      <= 1'b0;
            cfg_ready <= 1'b1;
            if (en) begin
              state   <= RUN;
              clk_out <= 1'b1;
            end else begin
              state   <= IDLE;
              clk_out <= 1'b0;
              busy    <= 1'b0;
            end
          end else begin
            // Mid-period: the running ratio stays in force even when a new one is pending.
            cnt     <= cnt_inc;
            clk_out <= (cnt_inc < (div_q >> 1));
            tick    <= (cnt_inc == div_q - DIV_W'(1));
            if (state == RUN && good_ratio) begin
              state     <= PEND;
              div_nxt   <= cfg_div;
              cfg_ready <= 1'b0;
            end
          end
        end
        default: begin
          state     <= IDLE;
          clk_out   <= 1'b0;
          tick      <= 1'b0;
          busy      <= 1'b0;
          cfg_ready <= 1'b1;
        end
      endcase
    end
  end

`ifdef CLKDIV_PCNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      period_cnt <= '0;
    else if (tick)
      period_cnt <= period_cnt + 16'd1;
  end
`endif

endmodule
